// File: rtl/ram_arb_pkg.sv
// Shared types and RAM command encodings for the two-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StWaitRd,
        StDone
    } state_e;

    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_WDATA = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b10;
    localparam logic [1:0] CMD_RDATA = 2'b11;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        if (&req) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter serialising write/read transactions onto a command-strobe RAM.
// Define RAM_ARB_TIMEOUT_EN to bound the read-data wait to TIMEOUT cycles.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       p0_req,
    input  logic       p0_we,
    input  logic [7:0] p0_addr,
    input  logic [7:0] p0_wdata,
    output logic       p0_ack,
    output logic       p0_done,
    output logic [7:0] p0_rdata,
    output logic       p0_err,
    input  logic       p1_req,
    input  logic       p1_we,
    input  logic [7:0] p1_addr,
    input  logic [7:0] p1_wdata,
    output logic       p1_ack,
    output logic       p1_done,
    output logic [7:0] p1_rdata,
    output logic       p1_err,
    output logic       ram_rx_valid,
    output logic [9:0] ram_din,
    input  logic       ram_tx_valid,
    input  logic [7:0] ram_dout,
    output logic       busy
);

    state_e     state_q, state_d;
    logic       port_q, port_d;
    logic       last_grant_q, last_grant_d;
    logic       we_q, we_d;
    logic [7:0] wdata_q, wdata_d;
    logic [1:0] ack_q, ack_d;
    logic [1:0] done_q, done_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       rx_valid_q, rx_valid_d;
    logic [9:0] din_q, din_d;
    logic       busy_q, busy_d;

    logic       grant;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;
    logic [7:0] sel_payload;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      err_q, err_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT;
`endif

    rr_arb2 u_rr_arb2 (
        .req   ({p1_req, p0_req}),
        .last  (last_grant_q),
        .grant (grant)
    );

    always_comb begin
        sel_we      = grant ? p1_we    : p0_we;
        sel_addr    = grant ? p1_addr  : p0_addr;
        sel_wdata   = grant ? p1_wdata : p0_wdata;
        sel_payload = 8'(sel_addr[ADDR_SIZE-1:0]);
    end

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        ack_d        = '0;
        done_d       = '0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        rx_valid_d   = 1'b0;
        din_d        = '0;
`ifdef RAM_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (p0_req || p1_req) begin
                    // Address is captured straight into the registered command word.
                    state_d       = StAddr;
                    port_d        = grant;
                    last_grant_d  = grant;
                    we_d          = sel_we;
                    wdata_d       = sel_wdata;
                    ack_d[grant]  = 1'b1;
                    rx_valid_d    = 1'b1;
                    din_d         = {(sel_we ? CMD_WADDR : CMD_RADDR), sel_payload};
                end
            end
            StAddr: begin
                state_d    = StData;
                rx_valid_d = 1'b1;
                din_d      = we_q ? {CMD_WDATA, wdata_q} : {CMD_RDATA, 8'h00};
            end
            StData: begin
                if (we_q) begin
                    state_d        = StDone;
                    done_d[port_q] = 1'b1;
                end else begin
                    state_d = StWaitRd;
                end
`ifdef RAM_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            StWaitRd: begin
                // Data arriving on the final counted cycle still beats the timeout.
                if (ram_tx_valid) begin
                    state_d        = StDone;
                    done_d[port_q] = 1'b1;
                    if (port_q) rdata1_d = ram_dout;
                    else        rdata0_d = ram_dout;
`ifdef RAM_ARB_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d        = StDone;
                    done_d[port_q] = 1'b1;
                    err_d[port_q]  = 1'b1;
                    if (port_q) rdata1_d = 8'h00;
                    else        rdata0_d = 8'h00;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            port_q       <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            ack_q        <= '0;
            done_q       <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rx_valid_q   <= 1'b0;
            din_q        <= '0;
            busy_q       <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            rx_valid_q   <= rx_valid_d;
            din_q        <= din_d;
            busy_q       <= busy_d;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign p0_ack       = ack_q[0];
    assign p1_ack       = ack_q[1];
    assign p0_done      = done_q[0];
    assign p1_done      = done_q[1];
    assign p0_rdata     = rdata0_q;
    assign p1_rdata     = rdata1_q;
    assign ram_rx_valid = rx_valid_q;
    assign ram_din      = din_q;
    assign busy         = busy_q;
`ifdef RAM_ARB_TIMEOUT_EN
    assign p0_err       = err_q[0];
    assign p1_err       = err_q[1];
`else
    assign p0_err       = 1'b0;
    assign p1_err       = 1'b0;
`endif

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter ADDR_SIZE, default 8, SHALL set the width of the address field inside ram_din[7:0].
REQ-003 Parameter TIMEOUT, default 8, SHALL set the read-wait limit in cycles; it is used only when RAM_ARB_TIMEOUT_EN is defined.
REQ-004 The ports SHALL be as follows (N = 0, 1, one instance per requester):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- pN_req  in  1  transaction request, level; sampled only in IDLE.
- pN_we  in  1  1 = write, 0 = read.
- pN_addr  in  8  RAM address.
- pN_wdata  in  8  write data.
- pN_ack  out  1  one-cycle pulse: request accepted; fields latched.
- pN_done  out  1  one-cycle pulse: transaction complete.
- pN_rdata  out  8  read data; valid while pN_done=1 on a read.
- pN_err  out  1  read timeout flag; valid while pN_done=1.
- ram_rx_valid  out  1  command strobe to the RAM.
- ram_din  out  10  {cmd[1:0], payload[7:0]} to the RAM.
- ram_tx_valid  in  1  RAM read-data strobe.
- ram_dout  in  8  RAM read data.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 All outputs SHALL be registered.
REQ-006 The state machine SHALL have states IDLE, ADDR, DATA, WAIT_RD and DONE.
REQ-007 In IDLE with any pN_req=1, the block SHALL select a port, latch its we/addr/wdata, and go to ADDR.
REQ-008 With both requests high, the port not granted last SHALL win; last_grant resets to 1, so port 0 wins first.
REQ-009 In ADDR, the block SHALL drive ram_rx_valid=1 and ram_din={00,addr} for a write or {10,addr} for a read, and pulse pN_ack for the granted port.
REQ-010 In DATA, the block SHALL drive ram_rx_valid=1 and ram_din={01,wdata} for a write or {11,8'h00} for a read; writes then go to DONE, reads go to WAIT_RD.
REQ-011 In WAIT_RD, on ram_tx_valid=1 the block SHALL capture ram_dout into pN_rdata and go to DONE.
REQ-012 In DONE, the block SHALL pulse pN_done for one cycle and return to IDLE.
REQ-013 Latency, with req sampled at edge k:
- write: RAM commands in cycles k+1 and k+2; done at k+3.
- read: RAM commands in cycles k+1 and k+2; tx_valid at k+3; done with rdata at k+4.
REQ-014 ram_rx_valid SHALL be 0 in IDLE, WAIT_RD and DONE.
REQ-015 ram_tx_valid outside WAIT_RD SHALL be ignored.
REQ-016 Requests arriving while busy=1 SHALL wait and SHALL NOT be acked.
REQ-017 A request still held high when the block re-enters IDLE SHALL be treated as a new transaction.
REQ-018 pN_rdata SHALL hold its last captured value until the next read completes for that port.
REQ-019 The non-granted port's ack, done and err SHALL stay 0.

Reset
REQ-020 With rst_n=0, asynchronously and regardless of state, the block SHALL set state=IDLE, all ack/done/err=0, pN_rdata=0, ram_rx_valid=0, ram_din=0, busy=0, last_grant=1 and the timeout counter to 0.
REQ-021 A transaction interrupted by reset SHALL be dropped without a done pulse.

Configuration
REQ-022 With RAM_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_RD.
REQ-023 If TIMEOUT cycles pass without ram_tx_valid, the block SHALL go to DONE with pN_err=1 and pN_rdata=0.
REQ-024 A ram_tx_valid in the same cycle the count reaches TIMEOUT SHALL win: data is captured and err=0.
REQ-025 Without RAM_ARB_TIMEOUT_EN, WAIT_RD SHALL wait indefinitely and pN_err SHALL be tied to 0; the ports SHALL still be present.

Structure
REQ-026 Package ram_arb_pkg SHALL hold the state enum and the command constants CMD_WADDR=2'b00, CMD_WDATA=2'b01, CMD_RADDR=2'b10 and CMD_RDATA=2'b11.
REQ-027 A sub-module rr_arb2 SHALL implement the two-way round-robin pick: inputs req[1:0] and last; output grant index.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- p0 write addr 0x3C data 0xA5 -> ram_din 0x03C then 0x1A5 on consecutive cycles; p0_done 3 cycles after sampling.
- p1 read addr 0x3C after the above -> ram_din 0x23C then 0x300; p1_done with p1_rdata=0xA5 at k+4.
- p0 and p1 requests in the same cycle, first after reset -> p0 granted; next arbitration p1 granted, even with p0 still requesting.
- p1 requests while p0 is busy -> p1_ack only after p0_done; no ram_rx_valid overlap.
- rst_n low during DATA of a write -> all outputs 0 immediately; no done pulse; first request after release is granted to p0.
- RAM_ARB_TIMEOUT_EN with ram_tx_valid held 0 -> done with err=1 and rdata=0 after 8 WAIT_RD cycles; without the macro -> busy stays high.
